// File: rtl/tea_top.sv
// TEA block cipher core: one round per clock, 32 rounds per block.
// Define TEA_DECRYPT_EN to add the decrypt input and inverse rounds.
module tea_top (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [63:0]  plain_text,
    input  logic [127:0] key,
`ifdef TEA_DECRYPT_EN
    input  logic         decrypt,
`endif
    output logic         done,
    output logic [63:0]  cipher_text
);

    localparam logic [31:0] DELTA    = 32'h9E3779B9;
    localparam logic [31:0] DEC_SUM0 = 32'hC6EF3720;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [31:0]  v0, v1, sum;
    logic [127:0] key_r;
    logic [4:0]   rnd;
    logic [31:0]  v0_n, v1_n, sum_n;
    logic [31:0]  k0, k1, k2, k3;

`ifdef TEA_DECRYPT_EN
    logic dec_r;
`endif

    assign k0 = key_r[127:96];
    assign k1 = key_r[95:64];
    assign k2 = key_r[63:32];
    assign k3 = key_r[31:0];

    function automatic logic [31:0] mix(
        input logic [31:0] x,
        input logic [31:0] s,
        input logic [31:0] ka,
        input logic [31:0] kb
    );
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    // Encrypt uses the incremented sum; decrypt uses the current sum first.
    always_comb begin
        sum_n = sum + DELTA;
        v0_n  = v0 + mix(v1, sum_n, k0, k1);
        v1_n  = v1 + mix(v0_n, sum_n, k2, k3);
`ifdef TEA_DECRYPT_EN
        if (dec_r) begin
            v1_n  = v1 - mix(v0, sum, k2, k3);
            v0_n  = v0 - mix(v1_n, sum, k0, k1);
            sum_n = sum - DELTA;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            cipher_text <= '0;
            sum         <= '0;
            rnd         <= '0;
            v0          <= '0;
            v1          <= '0;
            key_r       <= '0;
`ifdef TEA_DECRYPT_EN
            dec_r       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        v0    <= plain_text[63:32];
                        v1    <= plain_text[31:0];
                        key_r <= key;
                        sum   <= '0;
                        rnd   <= '0;
                        done  <= 1'b0;
                        state <= RUN;
`ifdef TEA_DECRYPT_EN
                        dec_r <= decrypt;
                        if (decrypt) sum <= DEC_SUM0;
`endif
                    end
                end
                RUN: begin
                    v0  <= v0_n;
                    v1  <= v1_n;
                    sum <= sum_n;
                    rnd <= rnd + 5'd1;
                    if (rnd == 5'd31) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        cipher_text <= {v0_n, v1_n};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_top.sv
// Self-checking bench for tea_top: directed vectors plus randomized blocks
// checked against a software TEA model.
module tb_tea_top;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [63:0]  plain_text;
    logic [127:0] key;
    logic         done;
    logic [63:0]  cipher_text;
`ifdef TEA_DECRYPT_EN
    logic         decrypt;
`endif

    int tests = 0;
    int fails = 0;
    logic [63:0] last_ct;

    localparam logic [63:0]  EX_PT  = 64'h0123456789ABCDEF;
    localparam logic [127:0] EX_KEY = 128'h00112233445566778899AABBCCDDEEFF;

    always #5 clk = ~clk;

    tea_top dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .plain_text(plain_text),
        .key(key),
`ifdef TEA_DECRYPT_EN
        .decrypt(decrypt),
`endif
        .done(done),
        .cipher_text(cipher_text)
    );

    function automatic logic [63:0] tea_ref(
        input logic [63:0]  pt,
        input logic [127:0] k,
        input bit           dec
    );
        logic [31:0] v0, v1, s, d;
        logic [31:0] k0, k1, k2, k3;
        d  = 32'h9E3779B9;
        v0 = pt[63:32];
        v1 = pt[31:0];
        k0 = k[127:96];
        k1 = k[95:64];
        k2 = k[63:32];
        k3 = k[31:0];
        if (!dec) begin
            s = 0;
            for (int i = 0; i < 32; i++) begin
                s  = s + d;
                v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
                v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
            end
        end else begin
            s = d * 32;
            for (int i = 0; i < 32; i++) begin
                v1 = v1 - (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
                v0 = v0 - (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
                s  = s - d;
            end
        end
        return {v0, v1};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block: start pulse, scrambled inputs while busy, optional
    // second start at busy_rnd (0 = none), result checked 32 clocks later.
    task automatic run_block(input string tag, input logic [63:0] pt,
                             input logic [127:0] k, input bit dec,
                             input int busy_rnd);
        logic [63:0] exp;
        bit early;
        exp   = tea_ref(pt, k, dec);
        early = 0;
        @(negedge clk);
        start      = 1'b1;
        plain_text = pt;
        key        = k;
`ifdef TEA_DECRYPT_EN
        decrypt    = dec;
`endif
        @(negedge clk);
        start      = 1'b0;
        plain_text = rnd64();
        key        = rnd128();
`ifdef TEA_DECRYPT_EN
        decrypt    = 1'($urandom);
`endif
        for (int c = 2; c <= 32; c++) begin
            @(negedge clk);
            if (done !== 1'b0) early = 1;
            if (c == 16) check({tag, "_hold_run"}, cipher_text, last_ct);
            start = (c == busy_rnd + 1);
            if (start) plain_text = rnd64();
        end
        start = 1'b0;
        check({tag, "_no_early_done"}, 64'(early), 64'd0);
        @(negedge clk);
        check({tag, "_done"}, 64'(done), 64'd1);
        check(tag, cipher_text, exp);
        last_ct = exp;
    endtask

    initial begin
        logic [63:0]  ea, eb, ct;
        logic [127:0] ka, kb;
        bit           early;

        reset      = 1'b1;
        start      = 1'b0;
        plain_text = '0;
        key        = '0;
`ifdef TEA_DECRYPT_EN
        decrypt    = 1'b0;
`endif
        last_ct    = '0;
        repeat (2) @(negedge clk);
        check("reset_done", 64'(done), 64'd0);
        check("reset_ct", cipher_text, 64'd0);
        reset = 1'b0;

        run_block("zero_vec", 64'd0, 128'd0, 0, 0);
        check("zero_kat", cipher_text, 64'h41EA3A0A94BAA940);

        run_block("example", EX_PT, EX_KEY, 0, 0);
        ea = tea_ref(EX_PT, EX_KEY, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("example_hold_done", 64'(done), 64'd1);
            check("example_hold_ct", cipher_text, ea);
        end

        run_block("busy_start", 64'hFEDCBA9876543210, EX_KEY, 0, 10);

        // Abort mid-run; no done pulse may follow.
        @(negedge clk);
        start      = 1'b1;
        plain_text = EX_PT;
        key        = EX_KEY;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_done", 64'(done), 64'd0);
        check("abort_ct", cipher_text, 64'd0);
        last_ct = '0;
        early = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) early = 1;
        end
        check("abort_no_done", 64'(early), 64'd0);
        run_block("after_abort", EX_PT, EX_KEY, 0, 0);

        // Start held high: accepted once, re-accepted on first DONE cycle.
        ea = rnd64();
        eb = rnd64();
        ka = rnd128();
        kb = rnd128();
        @(negedge clk);
        start      = 1'b1;
        plain_text = ea;
        key        = ka;
`ifdef TEA_DECRYPT_EN
        decrypt    = 1'b0;
`endif
        @(negedge clk);
        plain_text = eb;
        key        = kb;
        early      = 0;
        for (int c = 2; c <= 32; c++) begin
            @(negedge clk);
            if (done !== 1'b0) early = 1;
        end
        check("held_no_early", 64'(early), 64'd0);
        @(negedge clk);
        check("held_done1", 64'(done), 64'd1);
        check("held_ct1", cipher_text, tea_ref(ea, ka, 0));
        @(negedge clk);
        start = 1'b0;
        check("held_reaccept", 64'(done), 64'd0);
        check("held_ct_keep", cipher_text, tea_ref(ea, ka, 0));
        early = 0;
        for (int c = 2; c <= 32; c++) begin
            @(negedge clk);
            if (done !== 1'b0) early = 1;
        end
        check("held_no_early2", 64'(early), 64'd0);
        @(negedge clk);
        check("held_done2", 64'(done), 64'd1);
        check("held_ct2", cipher_text, tea_ref(eb, kb, 0));
        last_ct = tea_ref(eb, kb, 0);

        for (int i = 0; i < 6; i++)
            run_block("random", rnd64(), rnd128(), 0,
                      int'($urandom_range(0, 20)));

`ifdef TEA_DECRYPT_EN
        run_block("enc_ex", EX_PT, EX_KEY, 0, 0);
        ct = last_ct;
        run_block("dec_ex", ct, EX_KEY, 1, 0);
        check("roundtrip_ex", cipher_text, EX_PT);
        for (int i = 0; i < 3; i++) begin
            ea = rnd64();
            ka = rnd128();
            run_block("enc_rnd", ea, ka, 0, 0);
            ct = last_ct;
            run_block("dec_rnd", ct, ka, 1, int'($urandom_range(0, 20)));
            check("roundtrip_rnd", cipher_text, ea);
        end
`else
        ct = '0;
        check("no_decrypt_idle_ct", cipher_text, last_ct | ct);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
